// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, receive FSM encoding and RX status bit map
package uart_pkg;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_BREAK
   } rx_state_t;

   localparam int IO_UART_RX_DAT_bit  = 3;
   localparam int IO_UART_RX_CNTL_bit = 4;

   localparam int RXST_NEMPTY  = 0;
   localparam int RXST_OVR     = 1;
   localparam int RXST_FRM     = 2;
   localparam int RXST_PAR     = 3;
   localparam int RXST_CNT_LSB = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO with push/pop, full/empty flags and occupancy count
module uart_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = count == '0;
   assign full    = count == CW'(DEPTH);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   // storage, written only when a push is accepted
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= wdata;

   // pointers wrap on their own because DEPTH is a power of two
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end

endmodule

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: memory-mapped 8N1 UART receiver with byte FIFO and sticky status
// Even-parity frames are supported when UART_RX_PARITY_EN is defined.
module uart_rx_mmio
   import uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ  = 12000000,
   parameter int BAUD_RATE    = 115200,
   parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rxd,
   input  logic        io_sel_dat,
   input  logic        io_sel_cntl,
   input  logic        io_rstrb,
   output logic [31:0] io_rdata,
   output logic        rx_irq
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int NW = $clog2(FIFO_DEPTH) + 1;

   logic          rxd_s1;
   logic          rxd_s2;
   rx_state_t     state;
   logic [CW-1:0] clk_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          push_stb;
   logic          frm_stb;
   logic          ovr;
   logic          frm;
   logic          par_err;
   logic          full;
   logic          empty;
   logic [7:0]    fifo_byte;
   logic [NW-1:0] count;
   logic          dat_rd;
   logic          st_rd;
   logic          ovr_set;
   logic [31:0]   status;
`ifdef UART_RX_PARITY_EN
   logic          par_stb;
`endif

   assign dat_rd  = io_rstrb & io_sel_dat;
   assign st_rd   = io_rstrb & io_sel_cntl & ~io_sel_dat;
   assign ovr_set = push_stb & full & ~dat_rd;
   assign rx_irq  = ~empty;

   // two-stage synchroniser, reset to idle-high so reset never looks like a start bit
   always_ff @(posedge clk or posedge reset)
      if (reset) {rxd_s1, rxd_s2} <= 2'b11;
      else {rxd_s1, rxd_s2} <= {rxd, rxd_s1};

   // frame receiver: mid-bit sampling on a per-bit down-counter, one-cycle event strobes
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state    <= RX_IDLE;
         clk_cnt  <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         push_stb <= 1'b0;
         frm_stb  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_stb  <= 1'b0;
`endif
      end else begin
         push_stb <= 1'b0;
         frm_stb  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_stb  <= 1'b0;
`endif
         case (state)
            RX_IDLE:
               if (!rxd_s2) begin
                  bit_cnt <= '0;
                  clk_cnt <= CW'(CLKS_PER_BIT / 2 - 1);
                  state   <= RX_START;
               end
            RX_START:
               if (clk_cnt != '0) clk_cnt <= clk_cnt - CW'(1);
               else begin
                  clk_cnt <= CW'(CLKS_PER_BIT - 1);
                  state   <= rxd_s2 ? RX_IDLE : RX_DATA;
               end
            RX_DATA:
               if (clk_cnt != '0) clk_cnt <= clk_cnt - CW'(1);
               else begin
                  clk_cnt <= CW'(CLKS_PER_BIT - 1);
                  shreg   <= {rxd_s2, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
                  if (bit_cnt == 3'd7) state <= RX_PARITY;
`else
                  if (bit_cnt == 3'd7) state <= RX_STOP;
`endif
               end
`ifdef UART_RX_PARITY_EN
            RX_PARITY:
               if (clk_cnt != '0) clk_cnt <= clk_cnt - CW'(1);
               else begin
                  clk_cnt <= CW'(CLKS_PER_BIT - 1);
                  par_stb <= rxd_s2 ^ (^shreg);
                  state   <= RX_STOP;
               end
`endif
            RX_STOP:
               if (clk_cnt != '0) clk_cnt <= clk_cnt - CW'(1);
               else if (rxd_s2) begin
                  push_stb <= 1'b1;
                  state    <= RX_IDLE;
               end else begin
                  frm_stb <= 1'b1;
                  state   <= RX_BREAK;
               end
            RX_BREAK:
               if (rxd_s2) state <= RX_IDLE;
            default:
               state <= RX_IDLE;
         endcase
      end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_stb),
      .pop   (dat_rd),
      .wdata (shreg),
      .rdata (fifo_byte),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // sticky error flags: a status read clears them, but a same-cycle set wins
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         ovr <= 1'b0;
         frm <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err <= 1'b0;
`endif
      end else begin
         ovr <= ovr_set | (ovr & ~st_rd);
         frm <= frm_stb | (frm & ~st_rd);
`ifdef UART_RX_PARITY_EN
         par_err <= par_stb | (par_err & ~st_rd);
`endif
      end

`ifndef UART_RX_PARITY_EN
   assign par_err = 1'b0;
`endif

   // status word assembly
   always_comb begin
      status = '0;
      status[RXST_NEMPTY] = ~empty;
      status[RXST_OVR] = ovr;
      status[RXST_FRM] = frm;
      status[RXST_PAR] = par_err;
      status[RXST_CNT_LSB +: NW] = count;
   end

   // registered read port: data select outranks status select, no select holds the value
   always_ff @(posedge clk or posedge reset)
      if (reset) io_rdata <= '0;
      else if (dat_rd) io_rdata <= {23'b0, ~empty, empty ? 8'h00 : fifo_byte};
      else if (st_rd) io_rdata <= status;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// tb_uart_rx_mmio: vector table, directed corner sequences and a randomized queue-model run
module tb_uart_rx_mmio;

   localparam int CPB = 10;

   typedef enum {V_SEND, V_FE, V_GLITCH, V_DAT, V_ST, V_NONE, V_BOTH} op_t;
   typedef struct {
      op_t         op;
      logic [7:0]  b;
      logic [31:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rxd = 1'b1;
   logic        io_sel_dat = 1'b0;
   logic        io_sel_cntl = 1'b0;
   logic        io_rstrb = 1'b0;
   logic [31:0] io_rdata;
   logic        rx_irq;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] cap;
   vec_t        tbl[$];

   always #5 clk = ~clk;

   uart_rx_mmio #(
      .CLK_FREQ_HZ (1000000),
      .BAUD_RATE   (100000),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rxd         (rxd),
      .io_sel_dat  (io_sel_dat),
      .io_sel_cntl (io_sel_cntl),
      .io_rstrb    (io_rstrb),
      .io_rdata    (io_rdata),
      .rx_irq      (rx_irq)
   );

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%03h, expected 0x%03h", name, got, exp);
      end
   endtask

   function automatic void add(input op_t op, input logic [7:0] b, input logic [31:0] exp);
      vec_t v;
      v.op = op;
      v.b = b;
      v.exp = exp;
      tbl.push_back(v);
   endfunction

   // drives one frame cycle by cycle; a strobe or reset can be placed on a chosen cycle (-1 = none)
   task automatic frame(input logic [7:0] b, input logic stop, input int stop_len,
                        input int dat_cyc, input int st_cyc, input int rst_cyc);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      for (int j = 0; j < 90 + stop_len; j++) begin
         rxd = (j >= 90) ? stop : bits[j / CPB];
         io_rstrb = (j == dat_cyc) || (j == st_cyc);
         io_sel_dat = j == dat_cyc;
         io_sel_cntl = j == st_cyc;
         if (j == rst_cyc) begin
            reset = 1'b1;
            rxd = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
         io_rstrb = 1'b0;
         io_sel_dat = 1'b0;
         io_sel_cntl = 1'b0;
         if (j == dat_cyc || j == st_cyc) cap = io_rdata;
      end
      rxd = 1'b1;
      repeat (stop ? 1 : 5) @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic dat, input logic cntl, input logic strobe, output logic [31:0] val);
      io_rstrb = strobe;
      io_sel_dat = dat;
      io_sel_cntl = cntl;
      @(posedge clk);
      #1;
      io_rstrb = 1'b0;
      io_sel_dat = 1'b0;
      io_sel_cntl = 1'b0;
      val = io_rdata;
   endtask

   initial begin
      logic [31:0] v;
      logic [31:0] e;
      logic [31:0] last;
      logic [7:0]  mq[$];
      logic        m_ovr;
      logic        m_frm;
      logic [7:0]  rb;
      int          r;

      add(V_ST, 8'h00, 32'h000);
      add(V_SEND, 8'h41, 32'h0);
      add(V_ST, 8'h00, 32'h011);
      add(V_DAT, 8'h00, 32'h141);
      add(V_ST, 8'h00, 32'h000);
      add(V_GLITCH, 8'h00, 32'h0);
      add(V_ST, 8'h00, 32'h000);
      add(V_FE, 8'h55, 32'h0);
      add(V_ST, 8'h00, 32'h004);
      add(V_ST, 8'h00, 32'h000);
      add(V_SEND, 8'h0A, 32'h0);
      add(V_DAT, 8'h00, 32'h10A);
      add(V_DAT, 8'h00, 32'h000);
      for (int i = 1; i <= 5; i++) add(V_SEND, 8'(i), 32'h0);
      add(V_ST, 8'h00, 32'h043);
      for (int i = 1; i <= 4; i++) add(V_DAT, 8'h00, 32'h100 + 32'(i));
      add(V_NONE, 8'h00, 32'h104);
      add(V_DAT, 8'h00, 32'h000);
      add(V_ST, 8'h00, 32'h000);
      add(V_SEND, 8'h7E, 32'h0);
      add(V_BOTH, 8'h00, 32'h17E);
      add(V_ST, 8'h00, 32'h000);

      repeat (3) @(posedge clk);
      #1;
      check("reset_rdata", io_rdata, 32'h0);
      check("reset_irq", {31'b0, rx_irq}, 32'h0);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         case (tbl[i].op)
            V_SEND:   frame(tbl[i].b, 1'b1, 10, -1, -1, -1);
            V_FE:     frame(tbl[i].b, 1'b0, 30, -1, -1, -1);
            V_GLITCH: begin
               rxd = 1'b0;
               repeat (3) @(posedge clk);
               #1;
               rxd = 1'b1;
               repeat (12) @(posedge clk);
               #1;
            end
            V_DAT:  begin rd(1'b1, 1'b0, 1'b1, v); check($sformatf("vec%0d_dat", i), v, tbl[i].exp); end
            V_ST:   begin rd(1'b0, 1'b1, 1'b1, v); check($sformatf("vec%0d_st", i), v, tbl[i].exp); end
            V_NONE: begin rd(1'b0, 1'b0, 1'b1, v); check($sformatf("vec%0d_none", i), v, tbl[i].exp); end
            V_BOTH: begin rd(1'b1, 1'b1, 1'b1, v); check($sformatf("vec%0d_both", i), v, tbl[i].exp); end
            default: ;
         endcase
      end

      for (int i = 0; i < 4; i++) frame(8'h10 + 8'(i), 1'b1, 10, -1, -1, -1);
      frame(8'h14, 1'b1, 10, 98, -1, -1);
      check("pop_at_full_push", cap, 32'h110);
      rd(1'b0, 1'b1, 1'b1, v);
      check("full_push_pop_no_ovr", v, 32'h041);
      for (int i = 1; i <= 4; i++) begin
         rd(1'b1, 1'b0, 1'b1, v);
         check($sformatf("drain%0d", i), v, 32'h110 + 32'(i));
      end
      rd(1'b0, 1'b1, 1'b1, v);
      check("drain_status", v, 32'h000);

      frame(8'h55, 1'b0, 30, -1, 98, -1);
      check("clr_read_value", cap, 32'h000);
      rd(1'b0, 1'b1, 1'b1, v);
      check("frm_set_beats_clear", v, 32'h004);
      rd(1'b0, 1'b1, 1'b1, v);
      check("frm_cleared", v, 32'h000);

      frame(8'h5A, 1'b1, 10, -1, -1, -1);
      rd(1'b0, 1'b1, 1'b1, v);
      check("pre_reset_status", v, 32'h011);
      frame(8'hC3, 1'b1, 10, -1, -1, 55);
      check("midframe_reset_rdata", io_rdata, 32'h0);
      check("midframe_reset_irq", {31'b0, rx_irq}, 32'h0);
      rd(1'b0, 1'b1, 1'b1, v);
      check("post_reset_status", v, 32'h000);
      frame(8'hC3, 1'b1, 10, -1, -1, -1);
      rd(1'b1, 1'b0, 1'b1, v);
      check("post_reset_byte", v, 32'h1C3);
      rd(1'b0, 1'b1, 1'b1, v);
      check("post_reset_clean", v, 32'h000);

      last = 32'h0;
      m_ovr = 1'b0;
      m_frm = 1'b0;
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 9);
         if (r <= 3) begin
            rb = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
               frame(rb, 1'b0, 30, -1, -1, -1);
               m_frm = 1'b1;
            end else begin
               frame(rb, 1'b1, 10, -1, -1, -1);
               if (mq.size() < 4) mq.push_back(rb);
               else m_ovr = 1'b1;
            end
         end else if (r <= 7 && r >= 6) begin
            e = 32'h0;
            e[0] = mq.size() != 0;
            e[1] = m_ovr;
            e[2] = m_frm;
            e[8:4] = 5'(mq.size());
            rd(1'b0, 1'b1, 1'b1, v);
            check($sformatf("rnd%0d_st", n), v, e);
            m_ovr = 1'b0;
            m_frm = 1'b0;
            last = e;
         end else if (r == 8) begin
            rd(1'b0, 1'b0, 1'b1, v);
            check($sformatf("rnd%0d_hold", n), v, last);
         end else begin
            e = (mq.size() != 0) ? {23'b0, 1'b1, mq.pop_front()} : 32'h0;
            rd(1'b1, r == 9, 1'b1, v);
            check($sformatf("rnd%0d_dat", n), v, e);
            last = e;
         end
         check($sformatf("rnd%0d_irq", n), {31'b0, rx_irq}, {31'b0, mq.size() != 0});
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
